// File: rtl/shape_color_classifier.sv
// Raster-scans one stored RGB frame through a synchronous-read port and reports the
// foreground object's dominant colour, coarse shape class and bounding box.
module shape_color_classifier #(
  parameter int unsigned IMG_W   = 160,
  parameter int unsigned IMG_H   = 120,
  parameter int unsigned AW      = 15,
  parameter int unsigned CW      = 4,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned MIN_RUN = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CW-1:0]            thr,
  output logic [AW-1:0]            mem_addr,
  input  logic [3*CW-1:0]          mem_data,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               color,
  output logic [1:0]               figure,
  output logic [$clog2(IMG_W)-1:0] x_min,
  output logic [$clog2(IMG_W)-1:0] x_max,
  output logic [$clog2(IMG_H)-1:0] y_min,
  output logic [$clog2(IMG_H)-1:0] y_max,
  output logic                     obj_found
);

  localparam int unsigned N  = IMG_W * IMG_H;
  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);
  localparam int unsigned WW = $clog2(IMG_W + 1);
  localparam int unsigned VW = $clog2(IMG_H + 1);
  localparam int unsigned SW = $clog2(N * ((1 << CW) - 1) + 1);

  typedef enum logic [2:0] {StIdle, StScan, StDrain, StClassify, StDone} state_e;

  state_e state_q, state_d;

  logic [CW-1:0] thr_q;
  logic [XW-1:0] x_cnt_q;
  logic [YW-1:0] y_cnt_q;
  logic [1:0]    drain_cnt_q;

  // Column/row tags delayed to line up with the returning read data.
  logic          tag_v_q [RD_LAT];
  logic [XW-1:0] tag_x_q [RD_LAT];
  logic [YW-1:0] tag_y_q [RD_LAT];

  logic [WW-1:0] run_width_q, prev_width_q;
  logic [VW-1:0] valid_rows_q, grow_q;
  logic [SW-1:0] sum_r_q, sum_g_q, sum_b_q;
  logic          found_q;
  logic [XW-1:0] bx_min_q, bx_max_q;
  logic [YW-1:0] by_min_q, by_max_q;

  logic          accept, scan_last, drain_last;
  logic          cons_v, lit, row_end;
  logic [XW-1:0] cons_x;
  logic [YW-1:0] cons_y;
  logic [CW-1:0] pix_r, pix_g, pix_b;
  logic [WW-1:0] width_new;
  logic [VW:0]   v_ext, g_ext, v_lo, v_hi;
  logic [1:0]    color_d, figure_d;

  assign accept     = start && (state_q == StIdle || state_q == StDone);
  assign scan_last  = (mem_addr == AW'(N - 1));
  assign drain_last = (drain_cnt_q == 2'(RD_LAT - 1));
  assign busy       = (state_q == StScan) || (state_q == StDrain) || (state_q == StClassify);
  assign done       = (state_q == StDone);

  assign pix_r     = mem_data[3*CW-1 -: CW];
  assign pix_g     = mem_data[2*CW-1 -: CW];
  assign pix_b     = mem_data[CW-1:0];
  assign cons_v    = tag_v_q[RD_LAT-1];
  assign cons_x    = tag_x_q[RD_LAT-1];
  assign cons_y    = tag_y_q[RD_LAT-1];
  assign lit       = cons_v && (pix_r >= thr_q || pix_g >= thr_q || pix_b >= thr_q);
  assign row_end   = cons_v && (cons_x == XW'(IMG_W - 1));
  assign width_new = run_width_q + WW'(lit);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StScan;
      StScan:         if (scan_last) state_d = StDrain;
      StDrain:        if (drain_last) state_d = StClassify;
      StClassify:     state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  // Shape decision from row statistics; one extra bit keeps v + v/4 from overflowing.
  always_comb begin
    v_ext = {1'b0, valid_rows_q};
    g_ext = {1'b0, grow_q};
    v_lo  = v_ext - (v_ext >> 2);
    v_hi  = (v_ext + (v_ext >> 2)) >> 1;
    if (g_ext <= v_ext && g_ext > v_lo) begin
      figure_d = 2'd1;
    end else if ((v_lo >> 1) < g_ext && g_ext < v_hi) begin
      figure_d = 2'd2;
    end else if (v_ext != '0) begin
      figure_d = 2'd3;
    end else begin
      figure_d = 2'd0;
    end
    if (sum_r_q > sum_g_q && sum_r_q > sum_b_q) begin
      color_d = 2'd1;
    end else if (sum_g_q > sum_r_q && sum_g_q > sum_b_q) begin
      color_d = 2'd2;
    end else if (sum_b_q > sum_r_q && sum_b_q > sum_g_q) begin
      color_d = 2'd3;
    end else begin
      color_d = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      thr_q        <= '0;
      mem_addr     <= '0;
      x_cnt_q      <= '0;
      y_cnt_q      <= '0;
      drain_cnt_q  <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_v_q[i] <= 1'b0;
        tag_x_q[i] <= '0;
        tag_y_q[i] <= '0;
      end
      run_width_q  <= '0;
      prev_width_q <= '0;
      valid_rows_q <= '0;
      grow_q       <= '0;
      sum_r_q      <= '0;
      sum_g_q      <= '0;
      sum_b_q      <= '0;
      found_q      <= 1'b0;
      bx_min_q     <= '0;
      bx_max_q     <= '0;
      by_min_q     <= '0;
      by_max_q     <= '0;
      color        <= '0;
      figure       <= '0;
      x_min        <= '0;
      x_max        <= '0;
      y_min        <= '0;
      y_max        <= '0;
      obj_found    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tag_v_q[0] <= (state_q == StScan);
      tag_x_q[0] <= x_cnt_q;
      tag_y_q[0] <= y_cnt_q;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v_q[i] <= tag_v_q[i-1];
        tag_x_q[i] <= tag_x_q[i-1];
        tag_y_q[i] <= tag_y_q[i-1];
      end

      if (accept) begin
        thr_q        <= thr;
        mem_addr     <= '0;
        x_cnt_q      <= '0;
        y_cnt_q      <= '0;
        drain_cnt_q  <= '0;
        run_width_q  <= '0;
        prev_width_q <= '0;
        valid_rows_q <= '0;
        grow_q       <= '0;
        sum_r_q      <= '0;
        sum_g_q      <= '0;
        sum_b_q      <= '0;
        found_q      <= 1'b0;
        bx_min_q     <= '0;
        bx_max_q     <= '0;
        by_min_q     <= '0;
        by_max_q     <= '0;
        color        <= '0;
        figure       <= '0;
        x_min        <= '0;
        x_max        <= '0;
        y_min        <= '0;
        y_max        <= '0;
        obj_found    <= 1'b0;
      end else begin
        if (state_q == StScan && !scan_last) begin
          mem_addr <= mem_addr + AW'(1);
          if (x_cnt_q == XW'(IMG_W - 1)) begin
            x_cnt_q <= '0;
            y_cnt_q <= y_cnt_q + YW'(1);
          end else begin
            x_cnt_q <= x_cnt_q + XW'(1);
          end
        end
        if (state_q == StDrain) drain_cnt_q <= drain_cnt_q + 2'd1;

        if (lit) begin
          sum_r_q  <= sum_r_q + SW'(pix_r);
          sum_g_q  <= sum_g_q + SW'(pix_g);
          sum_b_q  <= sum_b_q + SW'(pix_b);
          found_q  <= 1'b1;
          by_max_q <= cons_y;
          if (!found_q) by_min_q <= cons_y;
          if (!found_q || cons_x < bx_min_q) bx_min_q <= cons_x;
          if (!found_q || cons_x > bx_max_q) bx_max_q <= cons_x;
        end

        if (row_end) begin
          if (32'(width_new) > MIN_RUN) begin
            valid_rows_q <= valid_rows_q + VW'(1);
            if (width_new > prev_width_q) grow_q <= grow_q + VW'(1);
          end
          prev_width_q <= width_new;
          run_width_q  <= '0;
        end else if (lit) begin
          run_width_q <= width_new;
        end

        if (state_q == StClassify) begin
          color     <= color_d;
          figure    <= figure_d;
          x_min     <= bx_min_q;
          x_max     <= bx_max_q;
          y_min     <= by_min_q;
          y_max     <= by_max_q;
          obj_found <= found_q;
        end
      end
    end
  end

endmodule
